// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, operands shifted LSB-first.
// Operands enter over a valid/ready handshake and the result leaves over a second one.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic               w_accept;
  logic               w_last;
  logic               w_s;
  logic               w_carry_nx;

  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_sum_sr;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  // Single full-adder cell on the current LSBs.
  assign w_s        = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_carry_nx = (r_a_sr[0] & r_b_sr[0]) | (r_b_sr[0] & r_carry) | (r_a_sr[0] & r_carry);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept   = 1'b1;
          w_state_nx = ADD;
        end
      end
      ADD: begin
        if (w_last) begin
          w_state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // Handshake/status flags registered from the next state so they track the FSM with no comb path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nx == IDLE);
      r_out_valid <= (w_state_nx == DONE);
      r_busy      <= (w_state_nx != IDLE);
    end
  end

  // Operand/result shift registers, carry and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sr  <= a;
      r_b_sr  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == ADD) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
      r_carry  <= w_carry_nx;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum_sr;
  assign cout      = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed corner cases and random traffic on WIDTH=8,
// plus an independent random stream on a WIDTH=16 instance.
module tb_serial_adder;

  localparam int unsigned W8  = 8;
  localparam int unsigned W16 = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rst16_n;

  logic          iv8, ir8, ov8, or8, cin8, cout8, busy8;
  logic [W8-1:0] a8, b8, sum8;
  logic           iv16, ir16, ov16, or16, cin16, cout16, busy16;
  logic [W16-1:0] a16, b16, sum16;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic done16 = 1'b0;
  logic rdy_run = 1'b0;

  logic [W8:0]  exp_q8[$];
  logic [W16:0] exp_q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8), .busy(busy8)
  );

  serial_adder #(.WIDTH(W16)) dut16 (
    .clk(clk), .rst_n(rst16_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(cout16), .busy(busy16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Must be called just after a rising edge; returns #1 after the accepting edge.
  task automatic send8(input logic [W8-1:0] x, input logic [W8-1:0] y, input logic c, input int gap);
    logic ok;
    ok = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    a8 = x; b8 = y; cin8 = c; iv8 = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (ir8) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    if (ok) exp_q8.push_back({1'b0, x} + {1'b0, y} + {{W8{1'b0}}, c});
    else timeout_fail("w8_accept");
    #1;
    iv8 = 1'b0;
    a8 = W8'($urandom); b8 = W8'($urandom); cin8 = 1'($urandom);
  endtask

  task automatic wait_idle8();
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (exp_q8.size() == 0 && ir8) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("w8_drain");
    @(posedge clk);
    #1;
  endtask

  // Result monitors: a transfer happens on the edge after out_valid&&out_ready is seen here.
  always @(negedge clk) begin
    if (rst_n && ov8 && or8) begin
      if (exp_q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL w8_extra: unexpected result %0h", {cout8, sum8});
      end else begin
        check("w8_result", 64'({cout8, sum8}), 64'(exp_q8.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst16_n && ov16 && or16) begin
      if (exp_q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL w16_extra: unexpected result %0h", {cout16, sum16});
      end else begin
        check("w16_result", 64'({cout16, sum16}), 64'(exp_q16.pop_front()));
      end
    end
  end

  // WIDTH=16 producer with random gaps.
  initial begin
    logic [W16-1:0] x, y;
    logic c, ok;
    iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    wait (rst16_n === 1'b1);
    @(posedge clk);
    #1;
    for (int n = 0; n < 500; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      x = W16'($urandom); y = W16'($urandom); c = 1'($urandom);
      a16 = x; b16 = y; cin16 = c; iv16 = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
        @(negedge clk);
        if (ir16) begin
          ok = 1'b1;
          break;
        end
      end
      @(posedge clk);
      if (ok) exp_q16.push_back({1'b0, x} + {1'b0, y} + {{W16{1'b0}}, c});
      else timeout_fail("w16_accept");
      #1;
      iv16 = 1'b0;
      a16 = W16'($urandom); b16 = W16'($urandom);
    end
    done16 = 1'b1;
  end

  // WIDTH=16 consumer backpressure.
  initial begin
    or16 = 1'b1;
    wait (rst16_n === 1'b1);
    while (!done16) begin
      @(posedge clk);
      #1;
      or16 = ($urandom_range(0, 3) != 0);
    end
    or16 = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_prev;
    logic ok;
    rst_n = 1'b0; rst16_n = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; or8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sum", 64'(sum8), 64'(0));
    check("rst_cout", 64'(cout8), 64'(0));
    check("rst_out_valid", 64'(ov8), 64'(0));
    check("rst_busy", 64'(busy8), 64'(0));
    check("rst_in_ready", 64'(ir8), 64'(1));
    @(negedge clk);
    rst_n = 1'b1; rst16_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: out_valid rises exactly WIDTH edges after the accept edge.
    send8(8'h5A, 8'h33, 1'b0, 0);
    check("add_busy", 64'(busy8), 64'(1));
    check("add_in_ready", 64'(ir8), 64'(0));
    for (int k = 1; k <= int'(W8); k++) begin
      @(posedge clk);
      #1;
      if (k == int'(W8) - 1) check("lat_early", 64'(ov8), 64'(0));
      if (k == int'(W8)) begin
        check("lat_valid", 64'(ov8), 64'(1));
        check("lat_sum", 64'(sum8), 64'(8'h8D));
        check("lat_cout", 64'(cout8), 64'(0));
      end
    end
    wait_idle8();

    send8(8'hFF, 8'h01, 1'b0, 1);
    send8(8'hFF, 8'hFF, 1'b1, 0);
    send8(8'h00, 8'h00, 1'b1, 2);
    wait_idle8();

    // Backpressure: result held, new operands refused while in DONE.
    or8 = 1'b0;
    send8(8'h12, 8'h34, 1'b0, 0);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ov8) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("bp_valid");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
      end
      if (k == 3) iv8 = 1'b0;
      @(negedge clk);
      check("bp_out_valid", 64'(ov8), 64'(1));
      check("bp_in_ready", 64'(ir8), 64'(0));
      check("bp_hold", 64'({cout8, sum8}), 64'(9'h046));
    end
    or8 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 64'(ov8), 64'(0));
    check("bp_release_ready", 64'(ir8), 64'(1));
    repeat (W8 + 3) @(posedge clk);
    #1;
    check("bp_not_taken", 64'(busy8), 64'(0));

    // Asynchronous reset during the third ADD cycle discards the operation.
    send8(8'hC3, 8'h7E, 1'b1, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(ov8), 64'(0));
    check("mid_rst_busy", 64'(busy8), 64'(0));
    check("mid_rst_in_ready", 64'(ir8), 64'(1));
    exp_q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send8(8'h10, 8'h20, 1'b0, 0);
    wait_idle8();

    // Random traffic with random consumer stalls.
    rdy_run = 1'b1;
    fork
      begin
        for (int n = 0; n < 500; n++)
          send8(W8'($urandom), W8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        rdy_run = 1'b0;
      end
      begin
        while (rdy_run) begin
          @(posedge clk);
          #1;
          or8 = ($urandom_range(0, 1) != 0);
        end
      end
    join
    or8 = 1'b1;
    wait_idle8();

    // Tied-high handshakes: accept, WIDTH ADD cycles, one DONE cycle, one IDLE cycle.
    send8(W8'($urandom), W8'($urandom), 1'($urandom), 0);
    t_prev = cyc;
    for (int n = 0; n < 4; n++) begin
      send8(W8'($urandom), W8'($urandom), 1'($urandom), 0);
      check("period", 64'(cyc - t_prev), 64'(W8 + 2));
      t_prev = cyc;
    end
    wait_idle8();

    ok = 1'b0;
    for (int t = 0; t < 20000; t++) begin
      @(negedge clk);
      if (done16 && exp_q16.size() == 0 && ir16) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("w16_drain");
    check("w8_queue_empty", 64'(exp_q8.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
